// File: rtl/ldst_stride_agen.sv
// Strided address generator: expands one (base, stride, length) command into
// a sequence of element addresses under a request/grant handshake with stall.
module ldst_stride_agen #(
  parameter int unsigned WIDTH_ADDR = 32,
  parameter int unsigned WIDTH_LEN  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Req,
  input  logic [WIDTH_ADDR-1:0] I_Base,
  input  logic [WIDTH_ADDR-1:0] I_Stride,
  input  logic [WIDTH_LEN-1:0]  I_Length,
  output logic                  O_Ready,
  input  logic                  I_Stall,
  output logic                  O_Mem_Req,
  output logic [WIDTH_ADDR-1:0] O_Mem_Addr,
  input  logic                  I_Mem_Grant,
  output logic [WIDTH_LEN-1:0]  O_Index,
  output logic                  O_Busy,
  output logic                  O_End_Access
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                state;
  logic [WIDTH_ADDR-1:0] addr;
  logic [WIDTH_ADDR-1:0] stride;
  logic [WIDTH_LEN-1:0]  remain;
  logic [WIDTH_LEN-1:0]  index;
  logic                  xfer;

  assign xfer = (state == ISSUE) && !I_Stall && I_Mem_Grant;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      addr   <= '0;
      stride <= '0;
      remain <= '0;
      index  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (I_Req) begin
            addr   <= I_Base;
            stride <= I_Stride;
            remain <= I_Length;
            index  <= '0;
            state  <= (I_Length != '0) ? ISSUE : DONE;
          end
        end
        ISSUE: begin
          if (xfer) begin
            remain <= remain - WIDTH_LEN'(1);
            // The last transfer leaves addr/index untouched so the outputs
            // keep showing the final element through DONE and IDLE.
            if (remain == WIDTH_LEN'(1)) begin
              state <= DONE;
            end else begin
              addr  <= addr + stride;
              index <= index + WIDTH_LEN'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign O_Ready      = (state == IDLE);
  assign O_Busy       = (state == ISSUE) || (state == DONE);
  assign O_End_Access = (state == DONE);
  assign O_Mem_Req    = (state == ISSUE) && !I_Stall;
  assign O_Mem_Addr   = addr;
  assign O_Index      = index;

endmodule

// File: tb/tb_ldst_stride_agen.sv
// Directed bench for ldst_stride_agen: command sequences with per-cycle
// grant/stall patterns, checked against hand-derived addresses and timing.
module tb_ldst_stride_agen;

  logic        clk;
  logic        rst_n;
  logic        I_Req;
  logic [31:0] I_Base;
  logic [31:0] I_Stride;
  logic [15:0] I_Length;
  logic        O_Ready;
  logic        I_Stall;
  logic        O_Mem_Req;
  logic [31:0] O_Mem_Addr;
  logic        I_Mem_Grant;
  logic [15:0] O_Index;
  logic        O_Busy;
  logic        O_End_Access;

  int total;
  int bad;

  ldst_stride_agen #(
    .WIDTH_ADDR(32),
    .WIDTH_LEN (16)
  ) dut (
    .clock       (clk),
    .reset       (rst_n),
    .I_Req       (I_Req),
    .I_Base      (I_Base),
    .I_Stride    (I_Stride),
    .I_Length    (I_Length),
    .O_Ready     (O_Ready),
    .I_Stall     (I_Stall),
    .O_Mem_Req   (O_Mem_Req),
    .O_Mem_Addr  (O_Mem_Addr),
    .I_Mem_Grant (I_Mem_Grant),
    .O_Index     (O_Index),
    .O_Busy      (O_Busy),
    .O_End_Access(O_End_Access)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle c (1..) counts cycles after the accepting edge; bit c of the
  // patterns drives grant/stall in that cycle. Expected address of element n
  // is base + n*stride modulo 2^32.
  task automatic run_cmd(input string tag, input logic [31:0] base,
                         input logic [31:0] stride, input logic [15:0] len,
                         input logic [31:0] gnt_pat, input logic [31:0] stall_pat,
                         input int exp_end, input bit hold_req);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    #1;
    check({tag, ".ready_idle"}, {31'b0, O_Ready}, 32'd1);
    I_Req       = 1'b1;
    I_Base      = base;
    I_Stride    = stride;
    I_Length    = len;
    I_Mem_Grant = 1'b0;
    I_Stall     = 1'b0;
    step();
    for (int c = 1; c <= 40 && !done; c++) begin
      I_Req = hold_req;
      if (hold_req) begin
        I_Base   = 32'h500;
        I_Stride = 32'h0;
        I_Length = 16'd1;
      end
      I_Mem_Grant = gnt_pat[c];
      I_Stall     = stall_pat[c];
      #1;
      if (O_End_Access) begin
        check({tag, ".end_cycle"}, c, exp_end);
        check({tag, ".end_count"}, n, {16'b0, len});
        check({tag, ".end_noreq"}, {31'b0, O_Mem_Req}, 32'd0);
        check({tag, ".end_busy"}, {30'b0, O_Busy, O_Ready}, 32'd2);
        done = 1'b1;
      end else begin
        check({tag, ".busy"}, {30'b0, O_Busy, O_Ready}, 32'd2);
        check({tag, ".req"}, {31'b0, O_Mem_Req}, {31'b0, ~stall_pat[c]});
        if (O_Mem_Req) begin
          check({tag, ".addr"}, O_Mem_Addr, base + n * stride);
          check({tag, ".index"}, {16'b0, O_Index}, n);
          if (I_Mem_Grant) n++;
        end
      end
      step();
    end
    if (!done) check({tag, ".timeout"}, 32'd0, 32'd1);
    check({tag, ".ready_after"}, {29'b0, O_Ready, O_Busy, O_End_Access}, 32'd4);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    I_Req       = 1'b0;
    I_Base      = '0;
    I_Stride    = '0;
    I_Length    = '0;
    I_Stall     = 1'b0;
    I_Mem_Grant = 1'b0;
    repeat (2) step();
    check("rst.outs", {O_Mem_Addr[15:0], O_Index}, 32'd0);
    check("rst.flags", {28'b0, O_Ready, O_Busy, O_Mem_Req, O_End_Access}, 32'h8);
    rst_n = 1'b1;
    step();

    run_cmd("basic", 32'h100, 32'd4, 16'd3, 32'hFFFF_FFFF, 32'h0, 4, 1'b0);
    check("basic.hold_addr", O_Mem_Addr, 32'h108);
    check("basic.hold_idx", {16'b0, O_Index}, 32'd2);

    run_cmd("stall", 32'h0, 32'd8, 16'd4, 32'hFFFF_FFFB, 32'h18, 8, 1'b0);
    run_cmd("zero", 32'h700, 32'd4, 16'd0, 32'hFFFF_FFFF, 32'h0, 1, 1'b0);
    run_cmd("wrap", 32'hFFFF_FFFC, 32'd8, 16'd2, 32'hFFFF_FFFF, 32'h0, 3, 1'b0);
    check("wrap.last", O_Mem_Addr, 32'h0000_0004);
    run_cmd("neg", 32'h20, 32'hFFFF_FFF0, 16'd3, 32'hFFFF_FFFF, 32'h0, 4, 1'b0);
    check("neg.last", O_Mem_Addr, 32'h0);

    // Second request held through ISSUE/DONE is taken only once ready again.
    run_cmd("busy", 32'h300, 32'd4, 16'd2, 32'hFFFF_FFFF, 32'h0, 3, 1'b1);
    step();
    I_Req = 1'b0;
    I_Mem_Grant = 1'b1;
    #1;
    check("busy.second_req", {31'b0, O_Mem_Req}, 32'd1);
    check("busy.second_addr", O_Mem_Addr, 32'h500);
    step();
    check("busy.second_end", {31'b0, O_End_Access}, 32'd1);
    step();

    // Reset mid-command after two transfers of a length-5 command.
    I_Req = 1'b1; I_Base = 32'h1000; I_Stride = 32'd4; I_Length = 16'd5;
    I_Mem_Grant = 1'b1; I_Stall = 1'b0;
    step();
    I_Req = 1'b0;
    step();
    step();
    check("rstmid.pre_addr", O_Mem_Addr, 32'h1008);
    rst_n = 1'b0;
    #1;
    check("rstmid.outs", {O_Mem_Addr[15:0], O_Index}, 32'd0);
    check("rstmid.flags", {28'b0, O_Ready, O_Busy, O_Mem_Req, O_End_Access}, 32'h8);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstmid.no_end", {31'b0, O_End_Access}, 32'd0);
    end
    rst_n = 1'b1;
    step();
    run_cmd("post_rst", 32'h40, 32'h10, 16'd2, 32'hFFFF_FFFF, 32'h0, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
